// File: rtl/bus_node_receiver.sv
// Serial frame receiver for the shared node bus: reassembles src/dst/mode/data,
// checks the 4-bit CRC and filters frames against this node's address.
module bus_node_receiver #(
  parameter logic [3:0] MY_ADDR = 4'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bus_in,
  output logic        rx_valid,
  output logic [63:0] rx_data,
  output logic [3:0]  rx_src,
  output logic [1:0]  rx_mod,
  output logic        crc_err,
  output logic        busy,
  output logic [7:0]  frame_cnt,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SRC  = 3'd1,
    ST_DST  = 3'd2,
    ST_MOD  = 3'd3,
    ST_DATA = 3'd4,
    ST_CRC  = 3'd5
  } state_t;

  // One MSB-first step of the x^4+x+1 LFSR.
  function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  logic [5:0]  bit_cnt_r;
  logic [3:0]  lfsr_r;
  logic [73:0] frame_sh_r;   // {src, dst, mod, data} as shifted in
  logic [2:0]  crc_sh_r;

  logic        shift_s;
  logic        last_bit_s;
  logic [3:0]  crc_rx_s;
  logic        crc_ok_s;
  logic        accept_s;

  logic        rx_valid_r;
  logic [63:0] rx_data_r;
  logic [3:0]  rx_src_r;
  logic [1:0]  rx_mod_r;
  logic        crc_err_r;
  logic        busy_r;
  logic [7:0]  frame_cnt_r;
  logic [7:0]  err_cnt_r;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: the bit counter marks the end of each field.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: if (bus_in) state_next_s = ST_SRC;  else state_next_s = ST_IDLE;
      ST_SRC:  if (bit_cnt_r == 6'd3)  state_next_s = ST_DST;  else state_next_s = ST_SRC;
      ST_DST:  if (bit_cnt_r == 6'd3)  state_next_s = ST_MOD;  else state_next_s = ST_DST;
      ST_MOD:  if (bit_cnt_r == 6'd1)  state_next_s = ST_DATA; else state_next_s = ST_MOD;
      ST_DATA: if (bit_cnt_r == 6'd63) state_next_s = ST_CRC;  else state_next_s = ST_DATA;
      ST_CRC:  if (bit_cnt_r == 6'd3)  state_next_s = ST_IDLE; else state_next_s = ST_CRC;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Decode of the current bit: shifting, CRC verdict and address filter.
  always_comb begin
    shift_s    = 1'b0;
    last_bit_s = 1'b0;
    accept_s   = 1'b0;
    if ((state_r == ST_SRC) || (state_r == ST_DST) ||
        (state_r == ST_MOD) || (state_r == ST_DATA)) begin
      shift_s = 1'b1;
    end else begin
      shift_s = 1'b0;
    end
    if ((state_r == ST_CRC) && (bit_cnt_r == 6'd3)) begin
      last_bit_s = 1'b1;
    end else begin
      last_bit_s = 1'b0;
    end
    crc_rx_s = {crc_sh_r, bus_in};
    crc_ok_s = (crc_rx_s == lfsr_r);
    case (frame_sh_r[65:64])
      2'b00:   accept_s = (frame_sh_r[69:66] == MY_ADDR);
      2'b01:   accept_s = 1'b1;
      default: accept_s = 1'b0;
    endcase
  end

  // Field counter, CRC accumulator and frame shift registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt_r  <= 6'd0;
      lfsr_r     <= 4'd0;
      frame_sh_r <= 74'd0;
      crc_sh_r   <= 3'd0;
    end else begin
      if ((state_r == ST_IDLE) || (state_next_s != state_r)) begin
        bit_cnt_r <= 6'd0;
      end else begin
        bit_cnt_r <= bit_cnt_r + 6'd1;
      end
      if (state_r == ST_IDLE) begin
        lfsr_r <= 4'd0;
      end else if (shift_s) begin
        lfsr_r <= crc4_step(lfsr_r, bus_in);
      end
      if (shift_s) begin
        frame_sh_r <= {frame_sh_r[72:0], bus_in};
      end
      if (state_r == ST_CRC) begin
        crc_sh_r <= {crc_sh_r[1:0], bus_in};
      end
    end
  end

  // Registered strobes, held payload and saturating counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_valid_r  <= 1'b0;
      crc_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      rx_data_r   <= 64'd0;
      rx_src_r    <= 4'd0;
      rx_mod_r    <= 2'd0;
      frame_cnt_r <= 8'd0;
      err_cnt_r   <= 8'd0;
    end else begin
      rx_valid_r <= last_bit_s & crc_ok_s & accept_s;
      crc_err_r  <= last_bit_s & ~crc_ok_s;
      busy_r     <= (state_next_s != ST_IDLE);
      if (last_bit_s && crc_ok_s && accept_s) begin
        rx_data_r <= frame_sh_r[63:0];
        rx_src_r  <= frame_sh_r[73:70];
        rx_mod_r  <= frame_sh_r[65:64];
        if (frame_cnt_r != 8'hFF) begin
          frame_cnt_r <= frame_cnt_r + 8'd1;
        end
      end
      if (last_bit_s && !crc_ok_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

  assign rx_valid  = rx_valid_r;
  assign rx_data   = rx_data_r;
  assign rx_src    = rx_src_r;
  assign rx_mod    = rx_mod_r;
  assign crc_err   = crc_err_r;
  assign busy      = busy_r;
  assign frame_cnt = frame_cnt_r;
  assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_bus_node_receiver.sv
// Directed bench for bus_node_receiver: three nodes (addresses 0, 1, 3) each on
// their own bus line, with expected CRCs from a polynomial-division model.
module tb_bus_node_receiver;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]  rst;
  logic [2:0]  bus;
  logic        rx_valid [3];
  logic        crc_err [3];
  logic        busy [3];
  logic [63:0] rx_data [3];
  logic [3:0]  rx_src [3];
  logic [1:0]  rx_mod [3];
  logic [7:0]  frame_cnt [3];
  logic [7:0]  err_cnt [3];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit early;
  bit busy_bad;

  always @(posedge clock) cyc = cyc + 1;

  bus_node_receiver #(.MY_ADDR(4'd0)) u_node0 (
    .clock(clock), .reset(rst[0]), .bus_in(bus[0]), .rx_valid(rx_valid[0]),
    .rx_data(rx_data[0]), .rx_src(rx_src[0]), .rx_mod(rx_mod[0]), .crc_err(crc_err[0]),
    .busy(busy[0]), .frame_cnt(frame_cnt[0]), .err_cnt(err_cnt[0]));
  bus_node_receiver #(.MY_ADDR(4'd1)) u_node1 (
    .clock(clock), .reset(rst[1]), .bus_in(bus[1]), .rx_valid(rx_valid[1]),
    .rx_data(rx_data[1]), .rx_src(rx_src[1]), .rx_mod(rx_mod[1]), .crc_err(crc_err[1]),
    .busy(busy[1]), .frame_cnt(frame_cnt[1]), .err_cnt(err_cnt[1]));
  bus_node_receiver #(.MY_ADDR(4'd3)) u_node3 (
    .clock(clock), .reset(rst[2]), .bus_in(bus[2]), .rx_valid(rx_valid[2]),
    .rx_data(rx_data[2]), .rx_src(rx_src[2]), .rx_mod(rx_mod[2]), .crc_err(crc_err[2]),
    .busy(busy[2]), .frame_cnt(frame_cnt[2]), .err_cnt(err_cnt[2]));

  // Remainder of {msg, 0000} divided by x^4+x+1 (10011).
  function automatic logic [3:0] crc_ref(input logic [3:0] s, input logic [3:0] d,
                                         input logic [1:0] m, input logic [63:0] data);
    logic [77:0] r;
    r = {s, d, m, data, 4'b0000};
    for (int i = 77; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  function automatic logic [78:0] mk(input logic [3:0] s, input logic [3:0] d,
                                     input logic [1:0] m, input logic [63:0] data,
                                     input logic [3:0] crc);
    return {1'b1, s, d, m, data, crc};
  endfunction

  // Drives nbits of frame f onto node k; returns #1 after the edge that took the last bit.
  task automatic send_bits(input int k, input logic [78:0] f, input int nbits);
    early = 1'b0;
    busy_bad = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bus[k] = f[78 - i];
      @(posedge clock); #1;
      if (i < 78) begin
        if (rx_valid[k] || crc_err[k]) early = 1'b1;
        if (!busy[k]) busy_bad = 1'b1;
      end
    end
    if (nbits == 79) bus[k] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 3'b111;
    bus = 3'b000;
    repeat (2) @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (rx_valid[k] !== 1'b0 || crc_err[k] !== 1'b0 || busy[k] !== 1'b0 ||
          rx_data[k] !== 64'd0 || rx_src[k] !== 4'd0 || rx_mod[k] !== 2'd0 ||
          frame_cnt[k] !== 8'd0 || err_cnt[k] !== 8'd0) begin
        fails++;
        $display("FAIL reset node%0d: v=%b e=%b b=%b d=%h s=%h m=%h fc=%0d ec=%0d, required all zero",
                 k, rx_valid[k], crc_err[k], busy[k], rx_data[k], rx_src[k], rx_mod[k],
                 frame_cnt[k], err_cnt[k]);
      end
    end
    rst = 3'b000;
    @(posedge clock); #1;
  endtask

  task automatic test_unicast;
    send_bits(1, mk(4'd0, 4'd1, 2'b00, 64'h1, crc_ref(4'd0, 4'd1, 2'b00, 64'h1)), 79);
    tests++;
    if (early !== 1'b0 || busy_bad !== 1'b0) begin
      fails++; $display("FAIL unicast_inframe: early=%b busy_bad=%b, required 0 0", early, busy_bad);
    end
    tests++;
    if (rx_valid[1] !== 1'b1 || crc_err[1] !== 1'b0 || busy[1] !== 1'b0) begin
      fails++; $display("FAIL unicast_strobe: v=%b e=%b b=%b, required 1 0 0", rx_valid[1], crc_err[1], busy[1]);
    end
    tests++;
    if (rx_data[1] !== 64'h1 || rx_src[1] !== 4'd0 || rx_mod[1] !== 2'b00) begin
      fails++; $display("FAIL unicast_payload: d=%h s=%h m=%h, required 1 0 0", rx_data[1], rx_src[1], rx_mod[1]);
    end
    tests++;
    if (frame_cnt[1] !== 8'd1 || err_cnt[1] !== 8'd0) begin
      fails++; $display("FAIL unicast_cnt: fc=%0d ec=%0d, required 1 0", frame_cnt[1], err_cnt[1]);
    end
    @(posedge clock); #1;
    tests++;
    if (rx_valid[1] !== 1'b0) begin
      fails++; $display("FAIL unicast_pulse_width: v=%b, required 0", rx_valid[1]);
    end
    // Bad CRC with a different payload must not touch rx_*.
    send_bits(1, mk(4'hA, 4'd1, 2'b00, 64'hFFFF_0000_FFFF_0000,
                    crc_ref(4'hA, 4'd1, 2'b00, 64'hFFFF_0000_FFFF_0000) ^ 4'h1), 79);
    tests++;
    if (crc_err[1] !== 1'b1 || rx_valid[1] !== 1'b0) begin
      fails++; $display("FAIL badcrc_strobe: v=%b e=%b, required 0 1", rx_valid[1], crc_err[1]);
    end
    tests++;
    if (rx_data[1] !== 64'h1 || rx_src[1] !== 4'd0 || err_cnt[1] !== 8'd1 || frame_cnt[1] !== 8'd1) begin
      fails++; $display("FAIL badcrc_hold: d=%h s=%h ec=%0d fc=%0d, required 1 0 1 1",
                        rx_data[1], rx_src[1], err_cnt[1], frame_cnt[1]);
    end
  endtask

  task automatic test_zero_frame;
    send_bits(0, mk(4'd0, 4'd0, 2'b00, 64'd0, 4'h0), 79);
    tests++;
    if (rx_valid[0] !== 1'b1 || crc_err[0] !== 1'b0 || frame_cnt[0] !== 8'd1) begin
      fails++; $display("FAIL zero_good: v=%b e=%b fc=%0d, required 1 0 1", rx_valid[0], crc_err[0], frame_cnt[0]);
    end
    send_bits(0, mk(4'd0, 4'd0, 2'b00, 64'd0, 4'h1), 79);
    tests++;
    if (rx_valid[0] !== 1'b0 || crc_err[0] !== 1'b1 || err_cnt[0] !== 8'd1 || frame_cnt[0] !== 8'd1) begin
      fails++; $display("FAIL zero_bad: v=%b e=%b ec=%0d fc=%0d, required 0 1 1 1",
                        rx_valid[0], crc_err[0], err_cnt[0], frame_cnt[0]);
    end
  endtask

  task automatic test_filter;
    send_bits(2, mk(4'd2, 4'd5, 2'b00, 64'h5555_5555_5555_5555,
                    crc_ref(4'd2, 4'd5, 2'b00, 64'h5555_5555_5555_5555)), 79);
    tests++;
    if (early !== 1'b0 || rx_valid[2] !== 1'b0 || crc_err[2] !== 1'b0 ||
        frame_cnt[2] !== 8'd0 || err_cnt[2] !== 8'd0) begin
      fails++; $display("FAIL filter_unicast_other: v=%b e=%b fc=%0d ec=%0d, required 0 0 0 0",
                        rx_valid[2], crc_err[2], frame_cnt[2], err_cnt[2]);
    end
    send_bits(2, mk(4'd9, 4'd5, 2'b01, 64'hDEAD_BEEF_0123_4567,
                    crc_ref(4'd9, 4'd5, 2'b01, 64'hDEAD_BEEF_0123_4567)), 79);
    tests++;
    if (rx_valid[2] !== 1'b1 || rx_mod[2] !== 2'b01 || rx_src[2] !== 4'd9 ||
        rx_data[2] !== 64'hDEAD_BEEF_0123_4567 || frame_cnt[2] !== 8'd1) begin
      fails++; $display("FAIL filter_broadcast: v=%b m=%h s=%h d=%h fc=%0d, required 1 1 9 deadbeef01234567 1",
                        rx_valid[2], rx_mod[2], rx_src[2], rx_data[2], frame_cnt[2]);
    end
    send_bits(2, mk(4'd7, 4'd3, 2'b10, 64'h0F0F, crc_ref(4'd7, 4'd3, 2'b10, 64'h0F0F)), 79);
    tests++;
    if (early !== 1'b0 || rx_valid[2] !== 1'b0 || crc_err[2] !== 1'b0 ||
        frame_cnt[2] !== 8'd1 || rx_src[2] !== 4'd9 || rx_mod[2] !== 2'b01) begin
      fails++; $display("FAIL filter_reserved: v=%b e=%b fc=%0d s=%h m=%h, required 0 0 1 9 1",
                        rx_valid[2], crc_err[2], frame_cnt[2], rx_src[2], rx_mod[2]);
    end
  endtask

  task automatic test_back_to_back;
    int ca;
    logic rv_a;
    send_bits(2, mk(4'd2, 4'd3, 2'b00, 64'hAAAA_0000_1111_2222,
                    crc_ref(4'd2, 4'd3, 2'b00, 64'hAAAA_0000_1111_2222)), 79);
    ca = cyc;
    rv_a = rx_valid[2];
    send_bits(2, mk(4'd4, 4'd8, 2'b01, 64'h1234_5678_9ABC_DEF0,
                    crc_ref(4'd4, 4'd8, 2'b01, 64'h1234_5678_9ABC_DEF0)), 79);
    tests++;
    if (rv_a !== 1'b1) begin
      fails++; $display("FAIL b2b_first: v=%b, required 1", rv_a);
    end
    tests++;
    if (rx_valid[2] !== 1'b1 || (cyc - ca) !== 79 || early !== 1'b0 || busy_bad !== 1'b0) begin
      fails++; $display("FAIL b2b_second: v=%b gap=%0d early=%b busy_bad=%b, required 1 79 0 0",
                        rx_valid[2], cyc - ca, early, busy_bad);
    end
    tests++;
    if (rx_data[2] !== 64'h1234_5678_9ABC_DEF0 || rx_src[2] !== 4'd4 || frame_cnt[2] !== 8'd3) begin
      fails++; $display("FAIL b2b_payload: d=%h s=%h fc=%0d, required 123456789abcdef0 4 3",
                        rx_data[2], rx_src[2], frame_cnt[2]);
    end
  endtask

  task automatic test_reset_mid;
    send_bits(1, mk(4'd6, 4'd1, 2'b00, 64'h77, crc_ref(4'd6, 4'd1, 2'b00, 64'h77)), 40);
    rst[1] = 1'b1;
    bus[1] = 1'b0;
    @(posedge clock); #1;
    rst[1] = 1'b0;
    tests++;
    if (rx_valid[1] !== 1'b0 || crc_err[1] !== 1'b0 || busy[1] !== 1'b0 || rx_data[1] !== 64'd0 ||
        rx_src[1] !== 4'd0 || rx_mod[1] !== 2'd0 || frame_cnt[1] !== 8'd0 || err_cnt[1] !== 8'd0) begin
      fails++; $display("FAIL midreset_state: v=%b e=%b b=%b d=%h s=%h m=%h fc=%0d ec=%0d, required all zero",
                        rx_valid[1], crc_err[1], busy[1], rx_data[1], rx_src[1], rx_mod[1],
                        frame_cnt[1], err_cnt[1]);
    end
    early = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clock); #1;
      if (rx_valid[1] || crc_err[1] || busy[1]) early = 1'b1;
    end
    tests++;
    if (early !== 1'b0) begin
      fails++; $display("FAIL midreset_discard: activity=%b, required 0", early);
    end
    send_bits(1, mk(4'd5, 4'd1, 2'b00, 64'hCAFE, crc_ref(4'd5, 4'd1, 2'b00, 64'hCAFE)), 79);
    tests++;
    if (rx_valid[1] !== 1'b1 || rx_data[1] !== 64'hCAFE || rx_src[1] !== 4'd5 || frame_cnt[1] !== 8'd1) begin
      fails++; $display("FAIL midreset_next: v=%b d=%h s=%h fc=%0d, required 1 cafe 5 1",
                        rx_valid[1], rx_data[1], rx_src[1], frame_cnt[1]);
    end
  endtask

  task automatic test_err_saturation;
    rst[0] = 1'b1;
    @(posedge clock); #1;
    rst[0] = 1'b0;
    for (int n = 0; n < 255; n++) send_bits(0, mk(4'd0, 4'd0, 2'b00, 64'd0, 4'h1), 79);
    tests++;
    if (err_cnt[0] !== 8'd255 || crc_err[0] !== 1'b1) begin
      fails++; $display("FAIL sat_255: ec=%0d e=%b, required 255 1", err_cnt[0], crc_err[0]);
    end
    send_bits(0, mk(4'd0, 4'd0, 2'b00, 64'd0, 4'h1), 79);
    tests++;
    if (err_cnt[0] !== 8'd255 || crc_err[0] !== 1'b1 || frame_cnt[0] !== 8'd0) begin
      fails++; $display("FAIL sat_256: ec=%0d e=%b fc=%0d, required 255 1 0", err_cnt[0], crc_err[0], frame_cnt[0]);
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_zero_frame();
    test_filter();
    test_back_to_back();
    test_reset_mid();
    test_err_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
